// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the transmit FCS path: constants, byte step,
// frame sequencer states and keep decoding.
package crc32_pkg;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        ST_PASS,
        ST_TAIL,
        ST_MERGE,
        ST_FCS_REM,
        ST_FCS_FULL
    } state_t;

    // Reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Valid byte count of a word; anything but a legal tail pattern counts as full.
    function automatic logic [2:0] keep_to_count(input logic [3:0] keep, input logic last);
        if (!last) begin
            return 3'd4;
        end
        case (keep)
            4'b0001: return 3'd1;
            4'b0011: return 3'd2;
            4'b0111: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/crc32_step32.sv
// Combinational reflected CRC-32 step over a full 32-bit word, byte 0 first,
// each byte LSB first (so the word is consumed bit 0 upward).
module crc32_step32
    import crc32_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [31:0] data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ data;
        for (int i = 0; i < 32; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY_REFL) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/crc32_fcs_inserter.sv
// Transmit-path FCS inserter: passes frame words through and appends the
// Ethernet CRC-32 packed after the last data byte. Optional CRC32_FCS_BYPASS_EN.
module crc32_fcs_inserter
    import crc32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_keep,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready
`ifdef CRC32_FCS_BYPASS_EN
    ,
    input  logic        fcs_bypass
`endif
);

    state_t      state;
    logic [31:0] crc_q;
    logic [23:0] hold_q;
    logic [2:0]  cnt_q;
    logic [1:0]  idx_q;
    logic        rdy_en_q;
    logic        bypass;
    logic        s_fire;
    logic [2:0]  s_cnt;
    logic [7:0]  tail_byte;
    logic [31:0] crc_base;
    logic [31:0] crc_word_next;
    logic [31:0] crc_byte_next;
    logic [31:0] fcs;
    logic [31:0] merge_data;
    logic [31:0] rem_data;
    logic [3:0]  rem_keep;

    // A new frame may start in the same cycle the previous FCS word leaves.
    assign s_ready = rdy_en_q && (!m_valid || m_ready) &&
                     (state == ST_PASS ||
                      ((state == ST_FCS_REM || state == ST_FCS_FULL) && m_last));
    assign s_fire   = s_valid && s_ready;
    assign s_cnt    = keep_to_count(s_keep, s_last);
    assign crc_base = (state == ST_PASS) ? crc_q : CRC_INIT;
    assign fcs      = ~crc_q;

    crc32_step32 u_step32 (
        .crc      (crc_base),
        .data     (s_data),
        .crc_next (crc_word_next)
    );

    // NOTE: every path assigns tail_byte, so no latch is inferred.
    always_comb begin
        case (idx_q)
            2'd0:    tail_byte = hold_q[7:0];
            2'd1:    tail_byte = hold_q[15:8];
            default: tail_byte = hold_q[23:16];
        endcase
    end

    assign crc_byte_next = crc32_step8(crc_q, tail_byte);
    assign merge_data    = ((~crc_byte_next) << (8 * cnt_q)) |
                           ({8'd0, hold_q} & ~(32'hFFFF_FFFF << (8 * cnt_q)));
    assign rem_data      = fcs >> (8 * (3'd4 - cnt_q));
    assign rem_keep      = ~(4'hF << cnt_q);

`ifdef CRC32_FCS_BYPASS_EN
    logic byp_q;
    logic in_frame_q;

    assign bypass = in_frame_q ? byp_q : fcs_bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_q      <= 1'b0;
            in_frame_q <= 1'b0;
        end else if (s_fire) begin
            in_frame_q <= !s_last;
            if (!in_frame_q) begin
                byp_q <= fcs_bypass;
            end
        end
    end
`else
    assign bypass = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PASS;
            crc_q    <= CRC_INIT;
            hold_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            rdy_en_q <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (s_fire) begin
                if (bypass) begin
                    m_data  <= s_data;
                    m_keep  <= s_keep;
                    m_last  <= s_last;
                    m_valid <= 1'b1;
                    crc_q   <= crc_base;
                    state   <= ST_PASS;
                end else if (s_cnt == 3'd4) begin
                    m_data  <= s_data;
                    m_keep  <= 4'hF;
                    m_last  <= 1'b0;
                    m_valid <= 1'b1;
                    crc_q   <= crc_word_next;
                    state   <= s_last ? ST_FCS_FULL : ST_PASS;
                end else begin
                    // Short tail: bytes wait in hold_q until merged with the FCS head.
                    hold_q  <= s_data[23:0];
                    cnt_q   <= s_cnt;
                    idx_q   <= 2'd0;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    crc_q   <= crc_base;
                    state   <= ST_TAIL;
                end
            end else begin
                case (state)
                    ST_PASS: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                        end
                    end
                    ST_TAIL: begin
                        crc_q <= crc_byte_next;
                        idx_q <= idx_q + 2'd1;
                        if ({1'b0, idx_q} == cnt_q - 3'd1) begin
                            m_data  <= merge_data;
                            m_keep  <= 4'hF;
                            m_last  <= 1'b0;
                            m_valid <= 1'b1;
                            state   <= ST_MERGE;
                        end
                    end
                    ST_MERGE: begin
                        if (m_ready) begin
                            m_data <= rem_data;
                            m_keep <= rem_keep;
                            m_last <= 1'b1;
                            state  <= ST_FCS_REM;
                        end
                    end
                    ST_FCS_REM: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            crc_q   <= CRC_INIT;
                            state   <= ST_PASS;
                        end
                    end
                    ST_FCS_FULL: begin
                        if (m_ready) begin
                            if (m_last) begin
                                m_valid <= 1'b0;
                                crc_q   <= CRC_INIT;
                                state   <= ST_PASS;
                            end else begin
                                m_data <= fcs;
                                m_keep <= 4'hF;
                                m_last <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_PASS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc32_fcs_inserter.sv
// Self-checking bench for crc32_fcs_inserter: known vectors, reset abort,
// optional bypass, and random back-to-back frames against a byte-stream model.
`timescale 1ns/1ps
module tb_crc32_fcs_inserter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        string            name;
        int               n_in;
        logic [2:0][31:0] in_data;
        logic [3:0]       in_keep;
        int               n_out;
        logic [3:0][31:0] out_data;
        logic [3:0][3:0]  out_keep;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        fcs_bypass = 1'b0;

    int    checks = 0;
    int    errors = 0;
    bit    rand_ready = 1'b0;
    word_t in_q[$];
    word_t exp_q[$];
    logic [7:0] fb[$];
    vec_t  vecs[3];

    crc32_fcs_inserter dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready)
`ifdef CRC32_FCS_BYPASS_EN
        ,
        .fcs_bypass (fcs_bypass)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output monitor: in-order scoreboard plus stability under backpressure.
    word_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        word_t cur;
        word_t e;
        cur = '{data: m_data, keep: m_keep, last: m_last};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_word", 64'(cur), 64'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h, no word required", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(m_data), 64'(e.data));
                    check("out_keep", 64'(m_keep), 64'(e.keep));
                    check("out_last", 64'(m_last), 64'(e.last));
                end
            end
            stalled = m_valid && !m_ready;
            held    = cur;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input word_t w);
        int n;
        bit rdy;
        n = 0;
        s_data  = w.data;
        s_keep  = w.keep;
        s_last  = w.last;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: s_ready low for %0d cycles, required 1", n);
        end
        #1;
    endtask

    task automatic send_frame();
        while (in_q.size() != 0) begin
            send_word(in_q.pop_front());
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reference: data bytes followed by the FCS bytes, repacked 4 per word.
    task automatic build_frame();
        logic [7:0]  all[$];
        logic [31:0] crc;
        word_t       w;
        int          n;
        crc = 32'hFFFF_FFFF;
        foreach (fb[i]) begin
            crc ^= {24'd0, fb[i]};
            repeat (8) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        for (int i = 0; i < fb.size(); i += 4) begin
            n = (fb.size() - i > 4) ? 4 : fb.size() - i;
            w.data = $urandom;
            w.last = (i + 4 >= fb.size());
            for (int j = 0; j < n; j++) w.data[8*j +: 8] = fb[i+j];
            if (w.last) w.keep = 4'((1 << n) - 1);
            else if ($urandom_range(0, 3) == 0) w.keep = 4'($urandom);
            else w.keep = 4'hF;
            in_q.push_back(w);
        end
        all = fb;
        for (int j = 0; j < 4; j++) all.push_back(crc[8*j +: 8]);
        for (int i = 0; i < all.size(); i += 4) begin
            n = (all.size() - i > 4) ? 4 : all.size() - i;
            w.data = '0;
            for (int j = 0; j < n; j++) w.data[8*j +: 8] = all[i+j];
            w.keep = 4'((1 << n) - 1);
            w.last = (i + 4 >= all.size());
            exp_q.push_back(w);
        end
    endtask

    task automatic run_vec(input int v);
        word_t w;
        for (int i = 0; i < vecs[v].n_in; i++) begin
            w.data = vecs[v].in_data[i];
            w.last = (i == vecs[v].n_in - 1);
            w.keep = w.last ? vecs[v].in_keep : 4'hF;
            in_q.push_back(w);
        end
        for (int i = 0; i < vecs[v].n_out; i++) begin
            w.data = vecs[v].out_data[i];
            w.keep = vecs[v].out_keep[i];
            w.last = (i == vecs[v].n_out - 1);
            exp_q.push_back(w);
        end
        send_frame();
        s_valid = 1'b0;
        wait_drain(vecs[v].name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t first;

        vecs[0].name = "vec_123456789"; vecs[0].n_in = 3; vecs[0].in_keep = 4'b0001;
        vecs[0].in_data[0] = 32'h3433_3231; vecs[0].in_data[1] = 32'h3837_3635;
        vecs[0].in_data[2] = 32'h0000_0039; vecs[0].n_out = 4;
        vecs[0].out_data[0] = 32'h3433_3231; vecs[0].out_keep[0] = 4'hF;
        vecs[0].out_data[1] = 32'h3837_3635; vecs[0].out_keep[1] = 4'hF;
        vecs[0].out_data[2] = 32'hF439_2639; vecs[0].out_keep[2] = 4'hF;
        vecs[0].out_data[3] = 32'h0000_00CB; vecs[0].out_keep[3] = 4'b0001;

        vecs[1].name = "vec_a"; vecs[1].n_in = 1; vecs[1].in_keep = 4'b0001;
        vecs[1].in_data[0] = 32'h0000_0061; vecs[1].n_out = 2;
        vecs[1].out_data[0] = 32'hB7BE_4361; vecs[1].out_keep[0] = 4'hF;
        vecs[1].out_data[1] = 32'h0000_00E8; vecs[1].out_keep[1] = 4'b0001;

        vecs[2].name = "vec_zero_word"; vecs[2].n_in = 1; vecs[2].in_keep = 4'hF;
        vecs[2].in_data[0] = 32'h0000_0000; vecs[2].n_out = 2;
        vecs[2].out_data[0] = 32'h0000_0000; vecs[2].out_keep[0] = 4'hF;
        vecs[2].out_data[1] = 32'h2144_DF1C; vecs[2].out_keep[1] = 4'hF;

        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_after_rst", 64'(s_ready), 64'd1);

        for (int v = 0; v < 3; v++) run_vec(v);

        // Reset during the TAIL of a 3-byte-tail frame: only the first word escapes.
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        build_frame();
        first = exp_q[0];
        exp_q.delete();
        exp_q.push_back(first);
        send_frame();
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_m_valid", 64'(m_valid), 64'd0);
        check("abort_s_ready", 64'(s_ready), 64'd0);
        check("abort_pending", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_fcs", 64'(m_valid), 64'd0);
        run_vec(0);

`ifdef CRC32_FCS_BYPASS_EN
        fcs_bypass = 1'b1;
        in_q.push_back('{data: 32'h1122_3344, keep: 4'hF, last: 1'b0});
        exp_q.push_back('{data: 32'h1122_3344, keep: 4'hF, last: 1'b0});
        exp_q.push_back('{data: 32'hAB00_5566, keep: 4'b0011, last: 1'b1});
        send_frame();
        fcs_bypass = 1'b0;
        send_word('{data: 32'hAB00_5566, keep: 4'b0011, last: 1'b1});
        s_valid = 1'b0;
        wait_drain("bypass_frame");
        run_vec(1);
`endif

        // Random back-to-back frames with random backpressure and idle gaps.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            repeat ($urandom_range(1, 13)) fb.push_back(8'($urandom));
            build_frame();
            send_frame();
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        wait_drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
